// File: rtl/gshare_branch_predictor.sv
// Gshare direction predictor with a tagged BTB: combinational next-PC, update on resolution.
// Optional BP_STATS_EN adds saturating update/mispredict counters.
module gshare_branch_predictor #(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned BTB_ENTRIES = 32,
  parameter int unsigned GHR_BITS    = 5,
  parameter int unsigned CNT_BITS    = 2,
  localparam int unsigned IDX        = $clog2(BTB_ENTRIES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PC_WIDTH-1:0] fetch_pc,
  output logic [PC_WIDTH-1:0] predicted_pc,
  output logic [IDX-1:0]      pred_idx,
  input  logic                update_valid,
  input  logic [PC_WIDTH-1:0] update_pc,
  input  logic [IDX-1:0]      update_idx,
  input  logic                update_taken,
  input  logic [PC_WIDTH-1:0] update_target,
`ifdef BP_STATS_EN
  output logic [31:0]         stat_updates,
  output logic [31:0]         stat_mispredicts,
`endif
  output logic [GHR_BITS-1:0] ghr
);

  localparam int unsigned TAG_W = PC_WIDTH - IDX - 2;
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(1) << (CNT_BITS - 1);
  localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_WT - CNT_BITS'(1);

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [PC_WIDTH-1:0]    target_q [BTB_ENTRIES];
  logic [CNT_BITS-1:0]    cnt_q    [BTB_ENTRIES];
  logic [GHR_BITS-1:0]    ghr_q, ghr_d;

  logic [IDX-1:0]      f_idx;
  logic [TAG_W-1:0]    f_tag;
  logic                f_hit;
  logic [TAG_W-1:0]    u_tag;
  logic                u_hit;
  logic [CNT_BITS-1:0] u_cnt;
  logic [CNT_BITS-1:0] u_cnt_d;

  // Prediction reads pre-edge table contents; no bypass from a same-cycle update.
  always_comb begin
    f_idx        = fetch_pc[IDX+1:2] ^ IDX'(ghr_q);
    f_tag        = fetch_pc[PC_WIDTH-1:IDX+2];
    f_hit        = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    pred_idx     = f_idx;
    predicted_pc = fetch_pc + PC_WIDTH'(4);
    if (f_hit && cnt_q[f_idx][CNT_BITS-1]) begin
      predicted_pc = target_q[f_idx];
    end
  end

  always_comb begin
    u_tag   = update_pc[PC_WIDTH-1:IDX+2];
    u_hit   = valid_q[update_idx] && (tag_q[update_idx] == u_tag);
    u_cnt   = cnt_q[update_idx];
    u_cnt_d = u_cnt;
    if (update_taken) begin
      if (u_cnt != CNT_MAX) u_cnt_d = u_cnt + CNT_BITS'(1);
    end else begin
      if (u_cnt != '0) u_cnt_d = u_cnt - CNT_BITS'(1);
    end
    // Concatenate then truncate: keeps the low GHR_BITS, valid for GHR_BITS = 1 too.
    ghr_d = GHR_BITS'({ghr_q, update_taken});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      ghr_q   <= '0;
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
        cnt_q[i] <= CNT_WNT;
      end
    end else if (update_valid) begin
      ghr_q <= ghr_d;
      if (u_hit) begin
        cnt_q[update_idx] <= u_cnt_d;
      end else if (update_taken) begin
        valid_q[update_idx] <= 1'b1;
        cnt_q[update_idx]   <= CNT_WT;
      end
    end
  end

  // Tag/target need no reset: they are only meaningful behind a set valid bit.
  always_ff @(posedge clk) begin
    if (update_valid && update_taken && !reset) begin
      target_q[update_idx] <= update_target;
      if (!u_hit) tag_q[update_idx] <= u_tag;
    end
  end

  assign ghr = ghr_q;

`ifdef BP_STATS_EN
  logic [31:0] upd_cnt_q;
  logic [31:0] mis_cnt_q;
  logic        u_pred_taken;
  logic        u_mispredict;

  always_comb begin
    u_pred_taken = u_hit && u_cnt[CNT_BITS-1];
    u_mispredict = (u_pred_taken != update_taken) ||
                   (u_pred_taken && update_taken && (target_q[update_idx] != update_target));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_cnt_q <= '0;
      mis_cnt_q <= '0;
    end else if (update_valid) begin
      if (upd_cnt_q != '1) upd_cnt_q <= upd_cnt_q + 32'd1;
      if (u_mispredict && (mis_cnt_q != '1)) mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign stat_updates     = upd_cnt_q;
  assign stat_mispredicts = mis_cnt_q;
`endif

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench for gshare_branch_predictor (default parameters: 32 entries, 5-bit GHR, 2-bit counters).
module tb_gshare_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fetch_pc;
  logic [31:0] predicted_pc;
  logic [4:0]  pred_idx;
  logic        update_valid;
  logic [31:0] update_pc;
  logic [4:0]  update_idx;
  logic        update_taken;
  logic [31:0] update_target;
  logic [4:0]  ghr;
`ifdef BP_STATS_EN
  logic [31:0] stat_updates;
  logic [31:0] stat_mispredicts;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned n_upd  = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  idx;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  gshare_branch_predictor #(
    .PC_WIDTH(32), .BTB_ENTRIES(32), .GHR_BITS(5), .CNT_BITS(2)
  ) dut (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
    .predicted_pc(predicted_pc), .pred_idx(pred_idx),
    .update_valid(update_valid), .update_pc(update_pc), .update_idx(update_idx),
    .update_taken(update_taken), .update_target(update_target),
`ifdef BP_STATS_EN
    .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts),
`endif
    .ghr(ghr)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic fetch_check(input string tag, input logic [31:0] pc,
                             input logic [31:0] exp_pc, input logic [4:0] exp_idx);
    exp_t e;
    fetch_pc = pc;
    exp_q.push_back('{pc: exp_pc, idx: exp_idx});
    #1;
    e = exp_q.pop_front();
    checks++;
    assert (predicted_pc === e.pc) else begin
      errors++;
      $error("FAIL %s predicted_pc observed %h expected %h", tag, predicted_pc, e.pc);
    end
    checks++;
    assert (pred_idx === e.idx) else begin
      errors++;
      $error("FAIL %s pred_idx observed %h expected %h", tag, pred_idx, e.idx);
    end
  endtask

  task automatic ghr_check(input string tag, input logic [4:0] exp_ghr);
    checks++;
    assert (ghr === exp_ghr) else begin
      errors++;
      $error("FAIL %s ghr observed %h expected %h", tag, ghr, exp_ghr);
    end
  endtask

  task automatic do_update(input logic [31:0] pc, input logic [4:0] idx,
                           input logic taken, input logic [31:0] tgt);
    @(negedge clk);
    update_pc     = pc;
    update_idx    = idx;
    update_taken  = taken;
    update_target = tgt;
    update_valid  = 1'b1;
    n_upd++;
    @(posedge clk);
    #1;
    update_valid  = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    fetch_pc      = '0;
    update_valid  = 1'b0;
    update_pc     = '0;
    update_idx    = '0;
    update_taken  = 1'b0;
    update_target = '0;
    #1;
    fetch_check("reset_pc", 32'h100, 32'h104, 5'h00);
    ghr_check("reset_ghr", 5'h00);
    @(negedge clk);
    reset = 1'b0;
    #1;
    fetch_check("wrap", 32'hFFFF_FFFC, 32'h0000_0000, 5'h1F);

    // Allocate entry 0x10 for pc 0x40 (tag 0).
    do_update(32'h40, 5'h10, 1'b1, 32'h80);
    ghr_check("alloc_ghr", 5'h01);
    fetch_check("tag_miss", 32'h1044, 32'h1048, 5'h10);

    // Five not-taken updates to an empty entry shift history back to zero.
    for (int i = 0; i < 5; i++) do_update(32'h0, 5'h00, 1'b0, 32'h0);
    ghr_check("ghr_flush", 5'h00);
    fetch_check("alloc_hit", 32'h40, 32'h80, 5'h10);

    // update_valid low: nothing may change.
    @(negedge clk);
    update_pc = 32'h40; update_idx = 5'h10; update_taken = 1'b1; update_target = 32'h900;
    @(posedge clk);
    #1;
    ghr_check("idle_ghr", 5'h00);
    fetch_check("idle_hit", 32'h40, 32'h80, 5'h10);

    // Counter training on entry 0x10 (starts weakly taken = 2).
    for (int i = 0; i < 3; i++) do_update(32'h40, 5'h10, 1'b1, 32'h80);
    ghr_check("train_ghr", 5'h07);
    fetch_check("cnt3", 32'h5C, 32'h80, 5'h10);
    do_update(32'h40, 5'h10, 1'b0, 32'h0);
    fetch_check("cnt2", 32'h78, 32'h80, 5'h10);
    do_update(32'h40, 5'h10, 1'b0, 32'h0);
    fetch_check("cnt1", 32'h30, 32'h34, 5'h10);
    do_update(32'h40, 5'h10, 1'b0, 32'h0);
    do_update(32'h40, 5'h10, 1'b0, 32'h0);
    ghr_check("nt_ghr", 5'h10);
    // From a floor of 0, one taken gives 1 (not taken), a second gives 2.
    do_update(32'h40, 5'h10, 1'b1, 32'h80);
    fetch_check("floor_cnt1", 32'h44, 32'h48, 5'h10);
    do_update(32'h40, 5'h10, 1'b1, 32'h80);
    fetch_check("floor_cnt2", 32'h4C, 32'h80, 5'h10);
    do_update(32'h40, 5'h10, 1'b1, 32'h200);
    fetch_check("new_target", 32'h5C, 32'h200, 5'h10);

    // Same-cycle update and fetch of entry 0x10.
    @(negedge clk);
    update_pc = 32'h40; update_idx = 5'h10; update_taken = 1'b1; update_target = 32'h300;
    update_valid = 1'b1;
    n_upd++;
    fetch_check("same_cycle_old", 32'h5C, 32'h200, 5'h10);
    @(posedge clk);
    #1;
    update_valid = 1'b0;
    ghr_check("same_cycle_ghr", 5'h0F);
    fetch_check("same_cycle_new", 32'h7C, 32'h300, 5'h10);

    for (int i = 0; i < 8; i++) do_update(32'h40, 5'h10, 1'b1, 32'h300);
    ghr_check("pre_rst_ghr", 5'h1F);
    fetch_check("pre_rst_hit", 32'h3C, 32'h300, 5'h10);
`ifdef BP_STATS_EN
    checks++;
    assert (stat_updates === n_upd) else begin
      errors++;
      $error("FAIL stat_updates observed %0d expected %0d", stat_updates, n_upd);
    end
`endif

    // Asynchronous reset between clock edges.
    #1;
    reset = 1'b1;
    #1;
    ghr_check("async_rst_ghr", 5'h00);
    fetch_check("async_rst_pc", 32'h3C, 32'h40, 5'h0F);
`ifdef BP_STATS_EN
    checks++;
    assert (stat_updates === 32'd0) else begin
      errors++;
      $error("FAIL rst_stat_updates observed %0d expected 0", stat_updates);
    end
    checks++;
    assert (stat_mispredicts === 32'd0) else begin
      errors++;
      $error("FAIL rst_stat_mispredicts observed %0d expected 0", stat_mispredicts);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
    #1;
    fetch_check("post_rst_miss", 32'h40, 32'h44, 5'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
